mem_handshake_responder: RTL and testbench

//  Memory-side responder for the controller sequencer's fetch/data handshake.

---
 rtl/mem_pkg.sv | 18 +
 rtl/wait_counter.sv | 42 ++++
 rtl/mem_handshake_responder.sv | 152 +++++++++++++++
 tb/tb_mem_handshake_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, wait-counter size and FSM encoding for the memory responder
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_WAIT = 3'd1,
    ST_I_DONE = 3'd2,
    ST_D_PTR  = 3'd3,
    ST_D_WAIT = 3'd4,
    ST_D_DONE = 3'd5,
    ST_HOLD   = 3'd6
  } state_e;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable down-counter with zero flag, shared by every access phase
// 'extra' inserts one settle cycle before counting so the RAM sees the freshly registered address.
module wait_counter
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic                  extra,
  input  logic [WAIT_CNT_W-1:0] load_val,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pre_q, pre_d;

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    if (load) begin
      cnt_d = load_val;
      pre_d = extra;
    end else if (pre_q) begin
      pre_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
      pre_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end

  assign zero = !pre_q && (cnt_q == '0);

endmodule

// File: rtl/mem_handshake_responder.sv
// rtl/mem_handshake_responder.sv - fetch/data handshake responder driving wait-stated IRAM/DRAM
// Data requests win over fetches; HOLD blocks re-service of a request still held high.
module mem_handshake_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int INST_WAIT = 1,
  parameter int DATA_WAIT = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              instReq,
  input  logic [ADDR_W-1:0] instAddr,
  output logic              instReady,
  output logic [DATA_W-1:0] instData,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic              indirect,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataReady,
  output logic [DATA_W-1:0] dataRdata,
  output logic [ADDR_W-1:0] iramAddr,
  input  logic [DATA_W-1:0] iramRdata,
  output logic [ADDR_W-1:0] dramAddr,
  output logic              dramWe,
  output logic [DATA_W-1:0] dramWdata,
  input  logic [DATA_W-1:0] dramRdata
);

  localparam logic [WAIT_CNT_W-1:0] INST_WAIT_C = WAIT_CNT_W'(INST_WAIT);
  localparam logic [WAIT_CNT_W-1:0] DATA_WAIT_C = WAIT_CNT_W'(DATA_WAIT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] iram_addr_q, iram_addr_d;
  logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
  logic [DATA_W-1:0] dram_wdata_q, dram_wdata_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              we_q, we_d;
  logic              svc_data_q, svc_data_d;

  logic                  cnt_load;
  logic                  cnt_extra;
  logic [WAIT_CNT_W-1:0] cnt_val;
  logic                  cnt_zero;

  wait_counter u_wait_counter (
    .clk      (clk),
    .rstN     (rstN),
    .load     (cnt_load),
    .extra    (cnt_extra),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    iram_addr_d  = iram_addr_q;
    dram_addr_d  = dram_addr_q;
    dram_wdata_d = dram_wdata_q;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;
    we_d         = we_q;
    svc_data_d   = svc_data_q;
    cnt_load     = 1'b0;
    cnt_extra    = 1'b0;
    cnt_val      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (dataReq) begin
          dram_addr_d  = dataAddr;
          dram_wdata_d = dataWdata;
          we_d         = dataWe;
          svc_data_d   = 1'b1;
          cnt_load     = 1'b1;
          cnt_extra    = 1'b1;
          cnt_val      = DATA_WAIT_C;
          state_d      = indirect ? ST_D_PTR : ST_D_WAIT;
        end else if (instReq) begin
          iram_addr_d = instAddr;
          svc_data_d  = 1'b0;
          cnt_load    = 1'b1;
          cnt_extra   = 1'b1;
          cnt_val     = INST_WAIT_C;
          state_d     = ST_I_WAIT;
        end
      end
      ST_I_WAIT: begin
        if (cnt_zero) begin
          inst_data_d = iramRdata;
          state_d     = ST_I_DONE;
        end
      end
      ST_I_DONE: state_d = ST_HOLD;
      ST_D_PTR: begin
        // Pointer word's low bits become the effective address; wraps naturally.
        if (cnt_zero) begin
          dram_addr_d = dramRdata[ADDR_W-1:0];
          cnt_load    = 1'b1;
          cnt_val     = DATA_WAIT_C;
          state_d     = ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (cnt_zero) begin
          if (!we_q) data_rdata_d = dramRdata;
          state_d = ST_D_DONE;
        end
      end
      ST_D_DONE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (svc_data_q ? !dataReq : !instReq) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      iram_addr_q  <= '0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
      we_q         <= 1'b0;
      svc_data_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      iram_addr_q  <= iram_addr_d;
      dram_addr_q  <= dram_addr_d;
      dram_wdata_q <= dram_wdata_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
      we_q         <= we_d;
      svc_data_q   <= svc_data_d;
    end
  end

  assign instReady = (state_q == ST_I_DONE);
  assign dataReady = (state_q == ST_D_DONE);
  assign dramWe    = (state_q == ST_D_WAIT) && we_q && cnt_zero;
  assign instData  = inst_data_q;
  assign dataRdata = data_rdata_q;
  assign iramAddr  = iram_addr_q;
  assign dramAddr  = dram_addr_q;
  assign dramWdata = dram_wdata_q;

endmodule

// File: tb/tb_mem_handshake_responder.sv
// tb/tb_mem_handshake_responder.sv - scoreboard bench with reference memory model for the responder
module tb_mem_handshake_responder;

  localparam int IW = 1;
  localparam int DW = 2;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        chk_data;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        instReq, dataReq, dataWe, indirect;
  logic [7:0]  instAddr, dataAddr;
  logic [15:0] dataWdata;
  logic        instReady, dataReady, dramWe;
  logic [15:0] instData, dataRdata, dramWdata;
  logic [7:0]  iramAddr, dramAddr;
  logic [15:0] iramRdata, dramRdata;

  logic [15:0] iram_mem [256];
  logic [15:0] dram_mem [256];
  logic [15:0] ref_dram [256];

  rsp_t q_inst[$];
  rsp_t q_data[$];
  wr_t  q_wr[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  mem_handshake_responder #(
    .ADDR_W(8), .DATA_W(16), .INST_WAIT(IW), .DATA_WAIT(DW)
  ) dut (
    .clk(clk), .rstN(rstN),
    .instReq(instReq), .instAddr(instAddr), .instReady(instReady), .instData(instData),
    .dataReq(dataReq), .dataWe(dataWe), .indirect(indirect), .dataAddr(dataAddr),
    .dataWdata(dataWdata), .dataReady(dataReady), .dataRdata(dataRdata),
    .iramAddr(iramAddr), .iramRdata(iramRdata),
    .dramAddr(dramAddr), .dramWe(dramWe), .dramWdata(dramWdata), .dramRdata(dramRdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iramRdata = iram_mem[iramAddr];
  assign dramRdata = dram_mem[dramAddr];
  always @(posedge clk) if (dramWe) dram_mem[dramAddr] <= dramWdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  rsp_t mon_r;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (rstN) begin
      if (instReady || dataReady) chk("ready_overlap", {31'd0, instReady & dataReady}, 0);
      if (instReady) begin
        chk("inst_expected", q_inst.size(), 1);
        if (q_inst.size() > 0) begin
          mon_r = q_inst.pop_front();
          chk("inst_latency", cyc, mon_r.cyc);
          chk("inst_data", {16'd0, instData}, {16'd0, mon_r.data});
        end
      end
      if (dataReady) begin
        chk("data_expected", q_data.size(), 1);
        if (q_data.size() > 0) begin
          mon_r = q_data.pop_front();
          chk("data_latency", cyc, mon_r.cyc);
          if (mon_r.chk_data) chk("load_data", {16'd0, dataRdata}, {16'd0, mon_r.data});
        end
      end
      if (dramWe) begin
        chk("write_expected", q_wr.size(), 1);
        if (q_wr.size() > 0) begin
          mon_w = q_wr.pop_front();
          chk("write_cycle", cyc, mon_w.cyc);
          chk("write_addr", {24'd0, dramAddr}, {24'd0, mon_w.addr});
          chk("write_data", {16'd0, dramWdata}, {16'd0, mon_w.data});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_instReady"}, {31'd0, instReady}, 0);
    chk({tag, "_dataReady"}, {31'd0, dataReady}, 0);
    chk({tag, "_dramWe"}, {31'd0, dramWe}, 0);
    chk({tag, "_instData"}, {16'd0, instData}, 0);
    chk({tag, "_dataRdata"}, {16'd0, dataRdata}, 0);
    chk({tag, "_iramAddr"}, {24'd0, iramAddr}, 0);
    chk({tag, "_dramAddr"}, {24'd0, dramAddr}, 0);
    chk({tag, "_dramWdata"}, {16'd0, dramWdata}, 0);
  endtask

  // Called at posedge+#1 with the DUT idle; returns the same way.
  task automatic do_data(input logic we, input logic ind, input logic [7:0] addr,
                         input logic [15:0] wdata, input int hold, input int gap, input bit early);
    int k, lat;
    logic [7:0] eff, prev;
    bit got;
    eff = ind ? ref_dram[addr][7:0] : addr;
    lat = ind ? 2*DW + 3 : DW + 2;
    k = cyc + 1;
    q_data.push_back('{cyc: k + lat, data: ref_dram[eff], chk_data: !we});
    if (we) begin
      q_wr.push_back('{cyc: k + lat - 1, addr: eff, data: wdata});
      ref_dram[eff] = wdata;
    end
    dataReq = 1'b1; dataWe = we; indirect = ind; dataAddr = addr; dataWdata = wdata;
    if (early) begin
      @(posedge clk); #1 dataReq = 1'b0;
    end
    got = 0;
    prev = dramAddr;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (cyc == k) chk("dram_addr_first", {24'd0, dramAddr}, {24'd0, addr});
      if (dataReady) begin
        got = 1;
        chk("dram_addr_eff", {24'd0, prev}, {24'd0, eff});
      end
      prev = dramAddr;
    end
    chk("data_ready_seen", {31'd0, got}, 1);
    repeat (1 + hold) @(posedge clk);
    #1 dataReq = 1'b0;
    repeat (1 + gap) @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [7:0] addr, input int hold, input int gap, input bit early);
    int k;
    bit got;
    k = cyc + 1;
    q_inst.push_back('{cyc: k + IW + 2, data: iram_mem[addr], chk_data: 1'b1});
    instReq = 1'b1; instAddr = addr;
    if (early) begin
      @(posedge clk); #1 instReq = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (instReady) got = 1;
    end
    chk("inst_ready_seen", {31'd0, got}, 1);
    repeat (1 + hold) @(posedge clk);
    #1 instReq = 1'b0;
    repeat (1 + gap) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r, k;
    bit got;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      iram_mem[i] = 16'($urandom);
      dram_mem[i] = 16'($urandom);
      ref_dram[i] = dram_mem[i];
    end
    iram_mem[8'h10] = 16'h1A2B;
    dram_mem[8'h05] = 16'h0030; ref_dram[8'h05] = 16'h0030;
    dram_mem[8'h30] = 16'h1234; ref_dram[8'h30] = 16'h1234;

    rstN = 1'b0; instReq = 1'b0; dataReq = 1'b0; dataWe = 1'b0; indirect = 1'b0;
    instAddr = '0; dataAddr = '0; dataWdata = '0;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rstN = 1'b1;
    @(posedge clk); #1;

    do_fetch(8'h10, 0, 1, 0);
    do_data(1'b1, 1'b0, 8'h20, 16'hBEEF, 0, 1, 0);
    do_data(1'b0, 1'b0, 8'h20, 16'h0000, 0, 1, 0);
    do_data(1'b0, 1'b1, 8'h05, 16'h0000, 0, 1, 0);

    // Simultaneous requests: data first, fetch once dataReq has been seen low.
    k = cyc + 1;
    q_data.push_back('{cyc: k + DW + 2, data: ref_dram[8'h40], chk_data: 1'b1});
    instReq = 1'b1; instAddr = 8'h33; dataReq = 1'b1; dataWe = 1'b0; indirect = 1'b0; dataAddr = 8'h40;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (dataReady) got = 1;
    end
    chk("both_data_ready_seen", {31'd0, got}, 1);
    r = cyc;
    q_inst.push_back('{cyc: r + 3 + IW + 2, data: iram_mem[8'h33], chk_data: 1'b1});
    @(posedge clk); #1 dataReq = 1'b0;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (instReady) got = 1;
    end
    chk("both_inst_ready_seen", {31'd0, got}, 1);
    @(posedge clk); #1 instReq = 1'b0;
    @(posedge clk); #1;

    do_data(1'b1, 1'b0, 8'h21, 16'h5A5A, 3, 1, 0);
    do_data(1'b0, 1'b0, 8'h21, 16'h0000, 0, 0, 1);

    // Reset in the middle of a store: the write must never reach DRAM.
    a = 8'h77;
    dataReq = 1'b1; dataWe = 1'b1; indirect = 1'b0; dataAddr = a; dataWdata = ~ref_dram[a];
    repeat (2) @(posedge clk);
    #1 rstN = 1'b0;
    dataReq = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk); #1 rstN = 1'b1;
    @(posedge clk); #1;
    do_data(1'b0, 1'b0, a, 16'h0000, 0, 1, 0);
    do_fetch(8'h10, 1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(2, 0) == 0)
        do_fetch(8'($urandom), $urandom_range(3, 0), $urandom_range(2, 0), ($urandom_range(3, 0) == 0));
      else
        do_data(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
                $urandom_range(3, 0), $urandom_range(2, 0), ($urandom_range(3, 0) == 0));
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("inst_queue_drained", q_inst.size(), 0);
    chk("data_queue_drained", q_data.size(), 0);
    chk("write_queue_drained", q_wr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
